// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - TRV-32I decode/operand-fetch stage with hazard stalls and a valid/ready output register
//
// Sits between instruction fetch and execute. Drives rs1/rs2 read addresses to the
// register file straight from the incoming instruction, captures the combinational read
// data, corrects it for a writeback happening in the same cycle, stalls on load-use
// hazards, and holds one instruction in a valid/ready output register.
//
// Build option:
//   OPFETCH_WB_BYPASS_EN defined   - same-cycle writeback is bypassed into the captured
//                                    operands; no writeback stall.
//   OPFETCH_WB_BYPASS_EN undefined - no capture bypass; an instruction whose rs1/rs2 is
//                                    being written this cycle stalls one cycle so the
//                                    register file read returns the new value.
//   In both builds a held (stalled by execute) instruction has its operands refreshed
//   by writebacks to its source registers.
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   if_valid/if_ready            fetch handshake
//   if_instr, if_pc              instruction word and its PC
//   rf_rs1_addr, rf_rs2_addr     register-file read addresses (combinational from if_instr)
//   rf_rs1_data, rf_rs2_data     register-file read data
//   wb_write_en/rd_addr/rd_data  writeback port (same cycle as the register-file write)
//   ex_load_pending, ex_rd_addr  load in execute whose result is not yet available
//   flush                        redirect: squash this stage
//   id_valid/id_ready            execute handshake
//   id_pc, id_instr              captured PC and instruction
//   id_rs1_data, id_rs2_data     operands
//   id_rs1_addr, id_rs2_addr, id_rd_addr  decoded register fields

module operand_fetch #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,

    output logic [4:0]        rf_rs1_addr,
    output logic [4:0]        rf_rs2_addr,
    input  logic [XLEN-1:0]   rf_rs1_data,
    input  logic [XLEN-1:0]   rf_rs2_data,

    input  logic              wb_write_en,
    input  logic [4:0]        wb_rd_addr,
    input  logic [XLEN-1:0]   wb_rd_data,

    input  logic              ex_load_pending,
    input  logic [4:0]        ex_rd_addr,

    input  logic              flush,

    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   id_pc,
    output logic [31:0]       id_instr,
    output logic [XLEN-1:0]   id_rs1_data,
    output logic [XLEN-1:0]   id_rs2_data,
    output logic [4:0]        id_rs1_addr,
    output logic [4:0]        id_rs2_addr,
    output logic [4:0]        id_rd_addr
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            load_hz;
    logic            wb_hz;
    logic            accept;
    logic [XLEN-1:0] cap_rs1;
    logic [XLEN-1:0] cap_rs2;
    logic            refresh_rs1;
    logic            refresh_rs2;

    // Raw field extraction; hazard logic does not decode the opcode, so an
    // instruction that does not really use rs2 may still stall (conservative).
    assign rs1 = if_instr[19:15];
    assign rs2 = if_instr[24:20];
    assign rd  = if_instr[11:7];

    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    // x0 is never a hazard source: a load to x0 produces nothing to wait for.
    assign load_hz = ex_load_pending && (ex_rd_addr != 5'd0) &&
                     ((ex_rd_addr == rs1) || (ex_rd_addr == rs2));

`ifdef OPFETCH_WB_BYPASS_EN
    assign wb_hz = 1'b0;

    always_comb begin
        cap_rs1 = rf_rs1_data;
        if (rs1 == 5'd0) begin
            cap_rs1 = '0;
        end else if (wb_write_en && (wb_rd_addr == rs1)) begin
            cap_rs1 = wb_rd_data;
        end
    end

    always_comb begin
        cap_rs2 = rf_rs2_data;
        if (rs2 == 5'd0) begin
            cap_rs2 = '0;
        end else if (wb_write_en && (wb_rd_addr == rs2)) begin
            cap_rs2 = wb_rd_data;
        end
    end
`else
    // Without the bypass mux the register file still shows the old value this
    // cycle, so hold the instruction back one cycle until the write has landed.
    assign wb_hz = wb_write_en && (wb_rd_addr != 5'd0) &&
                   ((wb_rd_addr == rs1) || (wb_rd_addr == rs2));

    always_comb begin
        cap_rs1 = rf_rs1_data;
        if (rs1 == 5'd0) begin
            cap_rs1 = '0;
        end
    end

    always_comb begin
        cap_rs2 = rf_rs2_data;
        if (rs2 == 5'd0) begin
            cap_rs2 = '0;
        end
    end
`endif

    // flush dominates everything: the offered instruction is refused so fetch
    // does not believe it was consumed.
    assign if_ready = !flush && !load_hz && !wb_hz && ((state == EMPTY) || id_ready);
    assign accept   = if_valid && if_ready;

    // A held instruction must not leave with a stale operand when its source
    // register is written while execute is back-pressuring.
    assign refresh_rs1 = wb_write_en && (wb_rd_addr != 5'd0) && (wb_rd_addr == id_rs1_addr);
    assign refresh_rs2 = wb_write_en && (wb_rd_addr != 5'd0) && (wb_rd_addr == id_rs2_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            id_valid    <= 1'b0;
            id_pc       <= RESET_PC;
            id_instr    <= '0;
            id_rs1_data <= '0;
            id_rs2_data <= '0;
            id_rs1_addr <= '0;
            id_rs2_addr <= '0;
            id_rd_addr  <= '0;
        end else if (flush) begin
            state    <= EMPTY;
            id_valid <= 1'b0;
        end else if (accept) begin
            // Covers both the empty case and drain-and-refill in one cycle.
            state       <= FULL;
            id_valid    <= 1'b1;
            id_pc       <= if_pc;
            id_instr    <= if_instr;
            id_rs1_data <= cap_rs1;
            id_rs2_data <= cap_rs2;
            id_rs1_addr <= rs1;
            id_rs2_addr <= rs2;
            id_rd_addr  <= rd;
        end else begin
            case (state)
                FULL: begin
                    if (id_ready) begin
                        state    <= EMPTY;
                        id_valid <= 1'b0;
                    end else begin
                        if (refresh_rs1) begin
                            id_rs1_data <= wb_rd_data;
                        end
                        if (refresh_rs2) begin
                            id_rs2_data <= wb_rd_data;
                        end
                    end
                end
                default: begin
                    state    <= EMPTY;
                    id_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
